// File: rtl/cntr_pkg.sv
// cntr_pkg: shared state encodings and width helper for counter consumers.
package cntr_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  typedef enum logic [1:0] {IDLE = ST_IDLE, ARM = ST_ARM, RUN = ST_RUN} state_t;
  function automatic int dw(input int cw);
    return cw + 1;
  endfunction
endpackage

// File: rtl/cnt_wrap_detect.sv
// cnt_wrap_detect: flags the cycle where a modulo counter wraps, for either count direction.
module cnt_wrap_detect #(
  parameter int CNT_WIDTH = 4,
  parameter bit REVERSE   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT_WIDTH-1:0] i_cnt,
  output logic                 o_wrap
);
  logic [CNT_WIDTH-1:0] r_prev;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_prev <= '0;
    else     r_prev <= i_cnt;
  assign o_wrap = REVERSE ? (i_cnt > r_prev) : (i_cnt < r_prev);
endmodule

// File: rtl/pwm_cmp.sv
// pwm_cmp: registered PWM compare against a modulo counter, with a
// double-buffered duty value that only takes effect on period wrap.
module pwm_cmp
  import cntr_pkg::*;
#(
  parameter int CNT_MODULE = 16,
  parameter int CNT_WIDTH  = $clog2(CNT_MODULE),
  parameter bit REVERSE    = 1'b0,
  parameter bit POLARITY   = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [CNT_WIDTH-1:0] cnt,
  input  logic                 en,
  input  logic [CNT_WIDTH:0]   duty_data,
  input  logic                 duty_valid,
  output logic                 duty_ready,
  output logic                 pwm,
  output logic                 period_start,
  output logic                 duty_err
);
  localparam int DW = dw(CNT_WIDTH);
  localparam logic [DW-1:0] MAXD = DW'(CNT_MODULE);
  state_t          r_state;
  logic [DW-1:0]   r_active, r_pend, w_duty;
  logic            r_pend_vld, r_pwm, r_start, r_err;
  logic            w_wrap, w_xfer, w_clamp, w_load, w_run, w_hit;
  cnt_wrap_detect #(.CNT_WIDTH(CNT_WIDTH), .REVERSE(REVERSE)) u_wrap (
    .clk(CLK), .rst(RST), .i_cnt(cnt), .o_wrap(w_wrap)
  );
  assign w_xfer  = duty_valid & ~r_pend_vld;
  assign w_clamp = duty_data > MAXD;
  // IDLE adopts a pending value at once; ARM/RUN only on a wrap while enabled.
  assign w_load  = r_pend_vld & ((r_state == IDLE) | (en & w_wrap));
  assign w_duty  = w_load ? r_pend : r_active;
  assign w_run   = en & ((r_state == RUN) | ((r_state == ARM) & w_wrap));
  assign w_hit   = REVERSE ? ({1'b0, cnt} >= MAXD - w_duty) : ({1'b0, cnt} < w_duty);
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_state    <= IDLE;
      r_active   <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_pwm      <= !POLARITY;
      r_start    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= !en ? IDLE : (r_state == IDLE) ? ARM : w_wrap ? RUN : r_state;
      r_pwm      <= (w_run & w_hit) ? POLARITY : !POLARITY;
      r_start    <= en & w_wrap & (r_state != IDLE);
      r_err      <= w_xfer & w_clamp;
      r_pend_vld <= w_xfer | (r_pend_vld & ~w_load);
      if (w_load) r_active <= r_pend;
      if (w_xfer) r_pend <= w_clamp ? MAXD : duty_data;
    end
  assign duty_ready   = ~r_pend_vld;
  assign pwm          = r_pwm;
  assign period_start = r_start;
  assign duty_err     = r_err;
endmodule
